// File: rtl/uart_tx_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared types and line-level constants for the UART transmitter.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Transmitter frame phases; 3-bit encoding leaves room for PARITY.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic UART_START_BIT  = 1'b0;
  localparam logic UART_STOP_BIT   = 1'b1;
  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage
`default_nettype wire

// File: rtl/uart_tx_frame_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_frame_if
// Purpose  : Byte handshake and serial-line bundle for the UART transmitter.
//            master = byte producer, slave = transmitter.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_frame_if #(
  parameter int DATA_BITS = 8
);
  logic                 tx_valid;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_ready;
  logic                 serial_out;
  logic                 tx_busy;
  logic                 frame_done;

  modport master (
    output tx_valid, tx_data,
    input  tx_ready, serial_out, tx_busy, frame_done
  );

  modport slave (
    input  tx_valid, tx_data,
    output tx_ready, serial_out, tx_busy, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_frame_bit_timer.sv
`default_nettype none
// ============================================================================
// Module   : uart_bit_timer
// Purpose  : Free-running bit-period counter; bit_tick marks the last clock of
//            each CLKS_PER_BIT period. Synchronous clear beats enable.
// Revision : 1.0 - initial release
// ============================================================================
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic bit_tick
);
  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign bit_tick = (cnt_q == C_LAST);

  // Next count: clear wins, otherwise count and wrap on the tick.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = bit_tick ? '0 : cnt_q + 1'b1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule
`default_nettype wire

// File: rtl/uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_frame
// Purpose  : LSB-first UART transmitter: start, DATA_BITS data, optional even
//            parity, stop. Build option: UART_TX_PARITY_EN adds parity bit.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_frame_if.slave  bus
);
  localparam int BCW = $clog2(DATA_BITS + 1);
  localparam logic [BCW-1:0] C_LAST_BIT = BCW'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE   = IDLE;
  localparam logic [2:0] S_START  = START;
  localparam logic [2:0] S_DATA   = DATA;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = PARITY;
`endif
  localparam logic [2:0] S_STOP   = STOP;

  logic [2:0]           state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
  logic                 serial_q, serial_d;
  logic                 bit_tick;
  logic                 handshake;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  assign handshake = bus.tx_valid && (state_q == S_IDLE);

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (handshake),
    .enable   (state_q != S_IDLE),
    .bit_tick (bit_tick)
  );

  // Frame sequencing; serial level is derived from the next state so the
  // line switches on the same edge as the state, with no input-to-output path.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (handshake) begin
          state_d = S_START;
          shift_d = bus.tx_data;
        end
      end
      S_START: begin
        if (bit_tick) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
        end
      end
      S_DATA: begin
        if (bit_tick) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == C_LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_tick) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (bit_tick) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_START:  serial_d = UART_START_BIT;
      S_DATA:   serial_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: serial_d = parity_q;
`endif
      S_STOP:   serial_d = UART_STOP_BIT;
      default:  serial_d = UART_IDLE_LEVEL;
    endcase
  end

`ifdef UART_TX_PARITY_EN
  // Even parity of the byte, captured with the byte at the handshake.
  always_comb begin
    parity_d = parity_q;
    if (handshake) parity_d = ^bus.tx_data;
  end

  // Parity register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) parity_q <= 1'b0;
    else     parity_q <= parity_d;
  end
`endif

  // Main state, data and line registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      serial_q  <= UART_IDLE_LEVEL;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      serial_q  <= serial_d;
    end
  end

  assign bus.serial_out = serial_q;
  assign bus.tx_ready   = (state_q == S_IDLE);
  assign bus.tx_busy    = (state_q != S_IDLE);
  assign bus.frame_done = (state_q == S_STOP) && bit_tick;
endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_frame
// Purpose  : Directed self-checking bench for uart_tx_frame (CLKS_PER_BIT=10).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_frame;
  localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
  // Sent order is bit 0 first: start, data LSB-first, parity, stop.
  localparam logic [10:0] V_A5 = 11'b10101001010;
  localparam logic [10:0] V_00 = 11'b10000000000;
  localparam logic [10:0] V_FF = 11'b10111111110;
  localparam logic [10:0] V_3C = 11'b10001111000;
  localparam logic [10:0] V_81 = 11'b10100000010;
  localparam logic [10:0] V_07 = 11'b11000001110;
  localparam logic [10:0] V_03 = 11'b10000000110;
`else
  localparam int NB = 10;
  localparam logic [10:0] V_A5 = 11'b01101001010;
  localparam logic [10:0] V_00 = 11'b01000000000;
  localparam logic [10:0] V_FF = 11'b01111111110;
  localparam logic [10:0] V_3C = 11'b01001111000;
  localparam logic [10:0] V_81 = 11'b01100000010;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx_frame_if #(.DATA_BITS(8)) bus ();

  uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Checks the whole frame starting the clock after the handshake edge, then
  // the first IDLE clock after the stop bit.
  task automatic check_frame(input logic [10:0] vec, input string name);
    logic exp_done;
    for (int k = 1; k <= NB * CPB; k++) begin
      @(negedge clk);
      exp_done = (k == NB * CPB);
      n_checks++;
      if (bus.serial_out !== vec[(k-1)/CPB]) begin
        n_fail++;
        $display("FAIL %s serial_out clk %0d: got %b want %b", name, k, bus.serial_out, vec[(k-1)/CPB]);
      end
      n_checks++;
      if (bus.frame_done !== exp_done) begin
        n_fail++;
        $display("FAIL %s frame_done clk %0d: got %b want %b", name, k, bus.frame_done, exp_done);
      end
      n_checks++;
      if (bus.tx_ready !== 1'b0 || bus.tx_busy !== 1'b1) begin
        n_fail++;
        $display("FAIL %s ready/busy clk %0d: got %b/%b want 0/1", name, k, bus.tx_ready, bus.tx_busy);
      end
    end
    @(negedge clk);
    n_checks++;
    if (bus.tx_ready !== 1'b1 || bus.tx_busy !== 1'b0 || bus.serial_out !== 1'b1 || bus.frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle-after: got ready=%b busy=%b ser=%b done=%b want 1 0 1 0", name,
               bus.tx_ready, bus.tx_busy, bus.serial_out, bus.frame_done);
    end
  endtask

  // Offers a byte for one handshake edge, then drops tx_valid.
  task automatic send(input logic [7:0] d, input string name);
    @(negedge clk);
    n_checks++;
    if (bus.tx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready-before-send: got %b want 1", name, bus.tx_ready);
    end
    bus.tx_valid = 1'b1;
    bus.tx_data  = d;
    @(posedge clk);
    #1 bus.tx_valid = 1'b0;
  endtask

  // Checks the idle line for n clocks.
  task automatic check_idle(input int n, input string name);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.serial_out !== 1'b1 || bus.tx_ready !== 1'b1 || bus.tx_busy !== 1'b0 || bus.frame_done !== 1'b0) begin
        n_fail++;
        $display("FAIL %s idle clk %0d: got ser=%b ready=%b busy=%b done=%b want 1 1 0 0", name, k,
                 bus.serial_out, bus.tx_ready, bus.tx_busy, bus.frame_done);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.serial_out !== 1'b1 || bus.tx_ready !== 1'b1 || bus.tx_busy !== 1'b0 || bus.frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: got ser=%b ready=%b busy=%b done=%b want 1 1 0 0",
               bus.serial_out, bus.tx_ready, bus.tx_busy, bus.frame_done);
    end
    rst = 1'b0;
    check_idle(20, "reset_release");
  endtask

  task automatic test_single_frame();
    send(8'hA5, "a5");
    check_frame(V_A5, "a5");
    check_idle(3, "a5_post");
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'h00;
    @(posedge clk);
    fork
      check_frame(V_00, "b2b_00");
      begin
        repeat (50) @(posedge clk);
        #1 bus.tx_data = 8'hFF;
      end
    join
    @(posedge clk);
    #1 bus.tx_valid = 1'b0;
    check_frame(V_FF, "b2b_ff");
    check_idle(3, "b2b_post");
  endtask

  task automatic test_ignore_busy();
    send(8'h3C, "ign");
    fork
      check_frame(V_3C, "ign_3c");
      begin
        repeat (35) @(posedge clk);
        #1 bus.tx_data = 8'hFF;
        bus.tx_valid = 1'b1;
        @(posedge clk);
        #1 bus.tx_valid = 1'b0;
      end
    join
    check_idle(20, "ign_no_second");
  endtask

  task automatic test_reset_mid_frame();
    send(8'h3C, "rmf");
    for (int k = 1; k <= 44; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.serial_out !== V_3C[(k-1)/CPB]) begin
        n_fail++;
        $display("FAIL rmf_partial serial_out clk %0d: got %b want %b", k, bus.serial_out, V_3C[(k-1)/CPB]);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check_idle(20, "rmf_after_reset");
    send(8'h81, "rmf_81");
    check_frame(V_81, "rmf_81");
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    send(8'h07, "par07");
    check_frame(V_07, "par07");
    send(8'h03, "par03");
    check_frame(V_03, "par03");
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
